// File: rtl/vga_timing_gen2_if.sv
// Framebuffer read port between the scan controller and block-RAM video memory.
// fb_data is expected one cycle after fb_rd_en with the address it was issued on.
interface vga_timing_gen2_if #(
   parameter int HW = 10,
   parameter int VW = 10
);
   logic          fb_rd_en;
   logic [HW-1:0] fb_addr_h;
   logic [VW-1:0] fb_addr_v;
   logic [23:0]   fb_data;

   modport master (
      output fb_rd_en,
      output fb_addr_h,
      output fb_addr_v,
      input  fb_data
   );

   modport slave (
      input  fb_rd_en,
      input  fb_addr_h,
      input  fb_addr_v,
      output fb_data
   );
endinterface

// File: rtl/vga_timing_gen2.sv
// Parametrised VGA scan controller with a one-cycle-latency framebuffer read port.
// Optional macro VGA_PIXEL_DOUBLE_EN: half-resolution framebuffer, each stored pixel covers 2x2.
module vga_timing_gen2 #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   vga_timing_gen2_if.master  fb,
   output logic               hsync,
   output logic               vsync,
   output logic               valid,
   output logic [7:0]         vga_r,
   output logic [7:0]         vga_g,
   output logic [7:0]         vga_b,
   output logic               frame_start,
   output logic               vblank
);
   // One extra bit so window ends equal to a power-of-two total cannot wrap.
   localparam logic [HW:0]   H_ACT_END = (HW+1)'(H_ACTIVE);
   localparam logic [HW:0]   HS_BEG    = (HW+1)'(H_ACTIVE + H_FP);
   localparam logic [HW:0]   HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW:0]   V_ACT_END = (VW+1)'(V_ACTIVE);
   localparam logic [VW:0]   VS_BEG    = (VW+1)'(V_ACTIVE + V_FP);
   localparam logic [VW:0]   VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          act0;
   logic          hs0;
   logic          vs0;
   logic          vb0;

   assign act0 = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
   assign hs0  = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
   assign vs0  = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
   assign vb0  = ({1'b0, v_cnt} >= V_ACT_END);

   // The read strobe is combinational, so it is also masked while reset is held.
   assign fb.fb_rd_en = act0 && en && !rst;

`ifdef VGA_PIXEL_DOUBLE_EN
   assign fb.fb_addr_h = h_cnt >> 1;
   assign fb.fb_addr_v = v_cnt >> 1;
`else
   assign fb.fb_addr_h = h_cnt;
   assign fb.fb_addr_v = v_cnt;
`endif

   // Dropping en parks the scan at (0,0); re-enabling counts (0,0) on that same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   // Stage 1 lines the sync/blank outputs up with the framebuffer read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         valid       <= 1'b0;
         frame_start <= 1'b0;
         vblank      <= 1'b0;
      end else if (!en) begin
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         valid       <= 1'b0;
         frame_start <= 1'b0;
         vblank      <= 1'b0;
      end else begin
         hsync       <= hs0 ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= vs0 ? VSYNC_POL : ~VSYNC_POL;
         valid       <= act0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         vblank      <= vb0;
      end
   end

   assign {vga_r, vga_g, vga_b} = valid ? fb.fb_data : 24'h000000;
endmodule

// File: tb/tb_vga_timing_gen2.sv
// Self-checking bench for vga_timing_gen2 using a reduced 25x15 raster.
// A pixel-index reference model checks every cycle; tables and sequences cover the corners.
module tb_vga_timing_gen2;
   localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
   localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;
   localparam int HW = $clog2(HT);
   localparam int VW = $clog2(VT);
`ifdef VGA_PIXEL_DOUBLE_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif
   localparam logic [28:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0};

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       hsync, vsync, valid, frame_start, vblank;
   logic [7:0] vga_r, vga_g, vga_b;

   vga_timing_gen2_if #(.HW(HW), .VW(VW)) fb ();

   vga_timing_gen2 #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .fb(fb.master),
      .hsync(hsync), .vsync(vsync), .valid(valid),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start), .vblank(vblank)
   );

   always #5 clk = ~clk;

   // Synchronous-read framebuffer: content is {column, row, 0xA5}.
   always @(posedge clk)
      if (fb.fb_rd_en) fb.fb_data <= {8'(fb.fb_addr_h), 8'(fb.fb_addr_v), 8'hA5};

   wire [28:0] dut_out = {hsync, vsync, valid, frame_start, vblank, vga_r, vga_g, vga_b};

   int          errors = 0;
   int          checks = 0;
   int          pos = 0;
   logic [28:0] exp_out;

   typedef struct {
      int   x;
      int   y;
      logic valid;
      logic hsync;
      logic vsync;
      logic vblank;
      logic fs;
   } vec_t;
   vec_t tbl[13];

   function automatic int fbmap(input int c);
      return DBL ? c / 2 : c;
   endfunction

   // Expected registered outputs for the screen pixel with linear index p in the frame.
   function automatic logic [28:0] pix_out(input int p);
      int x, y;
      logic a, hs, vs, fs, vb;
      logic [23:0] rgb;
      x   = p % HT;
      y   = p / HT;
      a   = (x < HA) && (y < VA);
      hs  = (x >= HA + HFP) && (x < HA + HFP + HSW);
      vs  = (y >= VA + VFP) && (y < VA + VFP + VSW);
      fs  = (p == 0);
      vb  = (y >= VA);
      rgb = a ? {8'(fbmap(x)), 8'(fbmap(y)), 8'hA5} : 24'h0;
      return {~hs, ~vs, a, fs, vb, rgb};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus, called at a falling edge.
   task automatic step(input logic e);
      int c;
      en = e;
      #1;
      c = pos % FRAME;
      check("fb_rd_en", fb.fb_rd_en, e && (c % HT < HA) && (c / HT < VA));
      check("fb_addr", {fb.fb_addr_h, fb.fb_addr_v}, {HW'(fbmap(c % HT)), VW'(fbmap(c / HT))});
      @(posedge clk);
      if (e) begin
         exp_out = pix_out(c);
         pos++;
      end else begin
         exp_out = RST_OUT;
         pos = 0;
      end
      @(negedge clk);
      check("outputs", dut_out, exp_out);
   endtask

   task automatic restart();
      step(1'b0);
      step(1'b0);
   endtask

   initial begin
      tbl[0]  = '{0,  0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{5,  3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{15, 7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{16, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{17, 3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{18, 2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{21, 2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{22, 2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{0,  8,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{0,  10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{24, 11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{0,  12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{20, 14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      // Power-on reset with en high: everything at reset values, no read strobe.
      rst = 1'b0;
      en  = 1'b1;
      #1 rst = 1'b1;
      #2;
      check("reset_outputs", dut_out, RST_OUT);
      check("reset_rd_en", fb.fb_rd_en, 1'b0);
      @(posedge clk);
      #2;
      check("reset_outputs_clk", dut_out, RST_OUT);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      pos = 0;
      $display("reset: hsync=%b vsync=%b valid=%b", hsync, vsync, valid);

      foreach (tbl[i]) begin
         logic [23:0] er;
         restart();
         repeat (tbl[i].y * HT + tbl[i].x + 1) step(1'b1);
         er = tbl[i].valid ? {8'(fbmap(tbl[i].x)), 8'(fbmap(tbl[i].y)), 8'hA5} : 24'h0;
         check("tbl_sync", {hsync, vsync, valid, vblank, frame_start},
               {tbl[i].hsync, tbl[i].vsync, tbl[i].valid, tbl[i].vblank, tbl[i].fs});
         check("tbl_rgb", {vga_r, vga_g, vga_b}, er);
         $display("pixel (%0d,%0d): valid=%b hs=%b vs=%b vb=%b fs=%b rgb=%02h%02h%02h",
                  tbl[i].x, tbl[i].y, valid, hsync, vsync, vblank, frame_start, vga_r, vga_g, vga_b);
      end

      begin : line_timing
         int r1, r2, hf, lowcnt;
         logic pv;
         r1 = -1; r2 = -1; hf = -1; lowcnt = 0; pv = 1'b0;
         restart();
         for (int i = 0; i < 3 * HT; i++) begin
            step(1'b1);
            if (valid && !pv) begin
               if (r1 < 0) r1 = i;
               else if (r2 < 0) r2 = i;
            end
            if (r1 >= 0 && r2 < 0) begin
               if (!hsync) lowcnt++;
               if (!hsync && hf < 0) hf = i;
            end
            pv = valid;
         end
         check("line_period", r2 - r1, HT);
         check("hsync_start", hf - r1, HA + HFP);
         check("hsync_width", lowcnt, HSW);
         $display("line: period=%0d hsync_start=%0d hsync_width=%0d", r2 - r1, hf - r1, lowcnt);
      end

      begin : frame_timing
         int f1, f2, nfs, vlow, vbc, vf;
         f1 = -1; f2 = -1; nfs = 0; vlow = 0; vbc = 0; vf = -1;
         restart();
         for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step(1'b1);
            if (frame_start) begin
               nfs++;
               check("fs_with_valid", valid, 1'b1);
               if (f1 < 0) f1 = i;
               else if (f2 < 0) f2 = i;
            end
            if (f1 >= 0 && f2 < 0) begin
               if (!vsync) vlow++;
               if (vblank) vbc++;
               if (!vsync && vf < 0) vf = i;
            end
         end
         check("frame_period", f2 - f1, FRAME);
         check("frame_start_count", nfs, 3);
         check("vsync_width", vlow, VSW * HT);
         check("vsync_start", vf - f1, (VA + VFP) * HT);
         check("vblank_cycles", vbc, (VT - VA) * HT);
         $display("frame: period=%0d vsync_start=%0d vsync_cycles=%0d vblank_cycles=%0d",
                  f2 - f1, vf - f1, vlow, vbc);
      end

      // Drop en mid-frame at pixel (10,4) for 3 cycles.
      restart();
      repeat (4 * HT + 10 + 1) step(1'b1);
      check("pre_gap_valid", valid, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(1'b0);
         check("gap_valid", valid, 1'b0);
      end
      step(1'b1);
      check("fs_after_en", frame_start, 1'b1);
      $display("en gap: frame_start=%b valid=%b after en rose", frame_start, valid);

      // Asynchronous reset in the middle of a clock period.
      restart();
      repeat (40) step(1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_outputs", dut_out, RST_OUT);
      check("async_rst_rd_en", fb.fb_rd_en, 1'b0);
      @(posedge clk);
      #1;
      check("async_rst_hold", dut_out, RST_OUT);
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      pos = 0;
      step(1'b1);
      check("post_rst_fs", frame_start, 1'b1);
      $display("async reset: outputs returned to reset values");

      // Framebuffer address mapping around screen pixels (6..7, 4..5).
      restart();
      repeat (4 * HT + 6) step(1'b1);
      for (int k = 0; k < 4; k++) begin
         int sx, sy;
         sx = 6 + (k % 2);
         sy = 4 + (k / 2);
         #1;
         check("map_addr_h", fb.fb_addr_h, DBL ? 3 : sx);
         check("map_addr_v", fb.fb_addr_v, DBL ? 2 : sy);
         $display("screen (%0d,%0d) -> fb (%0d,%0d)", sx, sy, fb.fb_addr_h, fb.fb_addr_v);
         if (k == 1) repeat (HT - 1) step(1'b1);
         else step(1'b1);
      end

      // Random enable pattern against the reference model.
      for (int i = 0; i < 3000; i++) step($urandom_range(0, 99) < 95);
      $display("random: 3000 cycles with random en");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen2.md
# vga_timing_gen2

Parametrised VGA scan controller that replaces the fixed 640x480 controller feeding the board VGA pins. It generates horizontal/vertical sync, blanking and pixel colour, and drives a framebuffer read port with one-cycle synchronous-read latency, so block-RAM video memory can be used instead of combinational vmem. It also adds a run enable, a frame-start pulse and a vblank flag for the CPU side. It sits between the video memory and the VGA_* top-level outputs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- en  in  1  run enable
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr_h  out  HW  framebuffer column
- fb_addr_v  out  VW  framebuffer row
- fb_data  in  24  {R,G,B}, valid the cycle after fb_rd_en
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- valid  out  1  active video (drives VGA_BLANK_N)
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse on the output pixel (0,0)
- vblank  out  1  high while output line >= V_ACTIVE

## Operation
- Stage 0: counters h_cnt in 0..H_TOTAL-1, v_cnt in 0..V_TOTAL-1. Each line is active, then FP, SYNC, BP. h_cnt wraps to 0 at H_TOTAL-1; v_cnt increments on that wrap and wraps to 0 at V_TOTAL-1.
- act0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). fb_rd_en = act0 && en. fb_addr_h = h_cnt and fb_addr_v = v_cnt, combinational from the counters.
- hs0 is true for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs0 is the same window in lines.
- Stage 1 registers: hsync = hs0 ? HSYNC_POL : ~HSYNC_POL, and likewise vsync. valid = act0. frame_start = (h_cnt==0 && v_cnt==0). vblank = (v_cnt >= V_ACTIVE).
- Colour: {vga_r,vga_g,vga_b} = valid ? fb_data : 0. This is combinational from the stage-1 valid and fb_data, and is aligned with the stage-1 outputs.
- en low: counters are held at 0 synchronously and stage 1 loads reset values. When en rises, the first pixel (0,0) is counted that same cycle. A mid-frame drop of en therefore abandons the frame, with no partial resume.

## Timing
- Reset values: h_cnt = v_cnt = 0, hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, valid = 0, rgb = 0, frame_start = 0, vblank = 0, fb_rd_en = 0.
- Latency: every output lags the counters by exactly one cycle, matching the one-cycle read latency of fb_data.
- Line period is H_TOTAL cycles and frame period is H_TOTAL*V_TOTAL cycles. frame_start recurs every H_TOTAL*V_TOTAL cycles while en is high.
- Simultaneous h and v wrap: both counters go to 0 on the same edge.
- rst asserted mid-frame: all state returns to reset values immediately, independent of the clock.

## Configuration
- VGA_PIXEL_DOUBLE_EN defined: the framebuffer is half resolution. fb_addr_h = h_cnt>>1 and fb_addr_v = v_cnt>>1, so each stored pixel covers 2x2 screen pixels. fb_rd_en is unchanged. Sync and valid timing is identical.
- Not defined: fb_addr_h/fb_addr_v are 1:1 with the counters, as described above.

## Test plan
- Reset with default params → all outputs hold their reset values (hsync = vsync = 1, valid = 0, rgb = 0) while rst = 1 and en = 1.
- en = 1 with a model RAM returning {h[7:0], v[7:0], 8'hA5} → at valid pixel (5,3) the outputs are vga_r = 5, vga_g = 3, vga_b = 0xA5. No colour is emitted outside the active region.
- Count cycles → hsync is low for exactly 96 cycles, starting 656 cycles after valid first rises on a line; the line period is 800 cycles.
- Frame wrap → vsync is low for 2 lines starting at line 490. frame_start pulses once every 420000 cycles, coincident with the first valid = 1 of the frame; vblank is high for 45 lines.
- Drop en at pixel (100,200) for 3 cycles, then raise it → valid = 0 during the gap. The next frame_start appears 1 cycle after en rises.
- With VGA_PIXEL_DOUBLE_EN defined → screen pixels (6,4), (7,4), (6,5) and (7,5) all read framebuffer address (3,2).
